// File: rtl/ps2_kbd_pkg.sv
// Shared constants, receiver state encoding and seven-segment table for the
// PS/2 keyboard display block.
package ps2_kbd_pkg;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;

  localparam int HALF_PERIOD_DEF = 25_000_000;
  localparam int TIMEOUT_DEF     = 100_000;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_e;

  // Active-low {g,f,e,d,c,b,a}, indexed by hex digit.
  localparam logic [6:0] SEG_TABLE [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] seg7(input logic [3:0] digit);
    return SEG_TABLE[digit];
  endfunction

endpackage

// File: rtl/ps2_kbd_rx.sv
// PS/2 frame receiver: synchronizers, PS2_CLK glitch filter, frame FSM and
// inactivity timeout. Emits the received byte with a one-cycle valid.
module ps2_rx
  import ps2_kbd_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       rx_valid
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic [7:0]    filt_sr;
  logic          filt;
  logic          filt_d;
  logic          fall;
  logic          dat;
  rx_state_e     state;
  logic [7:0]    shift_reg;
  logic [2:0]    bit_cnt;
  logic          parity_ok;
  logic [TW-1:0] tcnt;

  assign dat  = dat_sync[1];
  assign fall = filt_d & ~filt;

  // Lines idle high, so synchronizers and filter reset to 1 to avoid a
  // spurious falling edge right after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      filt_sr  <= 8'hFF;
      filt     <= 1'b1;
      filt_d   <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      filt_sr  <= {filt_sr[6:0], clk_sync[1]};
      if (filt_sr == 8'hFF)      filt <= 1'b1;
      else if (filt_sr == 8'h00) filt <= 1'b0;
      filt_d   <= filt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RX_IDLE;
      shift_reg <= 8'h00;
      bit_cnt   <= 3'd0;
      parity_ok <= 1'b0;
      tcnt      <= '0;
    end else if (fall) begin
      tcnt <= '0;
      case (state)
        RX_IDLE: begin
          if (!dat) begin
            state     <= RX_DATA;
            shift_reg <= 8'h00;
            bit_cnt   <= 3'd0;
          end
        end
        RX_DATA: begin
          shift_reg <= {dat, shift_reg[7:1]};
          bit_cnt   <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state <= RX_PARITY;
        end
        RX_PARITY: begin
          parity_ok <= ^{shift_reg, dat};
          state     <= RX_STOP;
        end
        default: state <= RX_IDLE;
      endcase
    end else if (state != RX_IDLE) begin
      if (tcnt == TW'(TIMEOUT - 1)) begin
        state     <= RX_IDLE;
        shift_reg <= 8'h00;
        bit_cnt   <= 3'd0;
        tcnt      <= '0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end else begin
      tcnt <= '0;
    end
  end

  // Valid is asserted in the stop-bit edge cycle so the consumer's register
  // updates on the following cycle.
  assign rx_valid = fall && (state == RX_STOP) && dat && parity_ok;
  assign rx_byte  = shift_reg;

endmodule

// File: rtl/ps2_keyboard_display.sv
// PS/2 keyboard front end: make/break classification, last-make-code display
// on two seven-segment digits, and a 50% duty divided clock.
module ps2_keyboard_display
  import ps2_kbd_pkg::*;
#(
  parameter int HALF_PERIOD = HALF_PERIOD_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
  output logic [7:0] ps2_key_data,
  output logic       ps2_key_pressed,
  output logic [7:0] ps2_out,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic       clock_1hz
);

  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic          brk_flag;
  logic          ext_flag;
  logic [CW-1:0] div_cnt;

  // PS2_CLK/PS2_DAT are never driven here; the keyboard side owns them.
  ps2_rx #(
    .TIMEOUT (TIMEOUT)
  ) u_rx (
    .clk      (CLOCK_50),
    .rst      (reset),
    .ps2_clk  (PS2_CLK),
    .ps2_dat  (PS2_DAT),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      ps2_key_data    <= 8'h00;
      ps2_key_pressed <= 1'b0;
      ps2_out         <= 8'h00;
      brk_flag        <= 1'b0;
      ext_flag        <= 1'b0;
    end else begin
      ps2_key_pressed <= 1'b0;
      if (rx_valid) begin
        ps2_key_data <= rx_byte;
        if (rx_byte == EXT_CODE) begin
          ext_flag <= 1'b1;
        end else if (rx_byte == BREAK_CODE) begin
          brk_flag <= 1'b1;
        end else if (brk_flag) begin
          brk_flag <= 1'b0;
          ext_flag <= 1'b0;
        end else begin
          ps2_out         <= rx_byte;
          ps2_key_pressed <= 1'b1;
          ext_flag        <= 1'b0;
        end
      end
    end
  end

  // A make code always consumes the extended prefix.
  assert property (@(posedge CLOCK_50) disable iff (reset)
    ps2_key_pressed |-> !ext_flag);

  assign HEX0 = seg7(ps2_out[3:0]);
  assign HEX1 = seg7(ps2_out[7:4]);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      div_cnt   <= '0;
      clock_1hz <= 1'b0;
    end else if (div_cnt == CW'(HALF_PERIOD - 1)) begin
      div_cnt   <= '0;
      clock_1hz <= ~clock_1hz;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_display.sv
// Directed bench for ps2_keyboard_display: reset, divider, make/break/extended
// codes, corrupted frames, timeout, PS2_CLK glitch and mid-frame reset.
module tb_ps2_keyboard_display;

  localparam int HP      = 20;   // PS/2 clock half period in system cycles
  localparam int TIMEOUT = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2c_drv;
  logic       ps2d_drv;
  wire        ps2_clk_w;
  wire        ps2_dat_w;
  logic [7:0] ps2_key_data;
  logic       ps2_key_pressed;
  logic [7:0] ps2_out;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic       clock_1hz;

  assign ps2_clk_w = ps2c_drv;
  assign ps2_dat_w = ps2d_drv;

  ps2_keyboard_display #(
    .HALF_PERIOD (4),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .CLOCK_50        (clk),
    .reset           (rst),
    .PS2_CLK         (ps2_clk_w),
    .PS2_DAT         (ps2_dat_w),
    .ps2_key_data    (ps2_key_data),
    .ps2_key_pressed (ps2_key_pressed),
    .ps2_out         (ps2_out),
    .HEX0            (HEX0),
    .HEX1            (HEX1),
    .clock_1hz       (clock_1hz)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // pulse monitor
  int         pulse_cnt = 0;
  int         run = 0;
  int         last_run = 0;
  logic [7:0] data_at_pulse = 8'h00;

  always @(negedge clk) begin
    if (ps2_key_pressed) begin
      pulse_cnt++;
      run++;
      data_at_pulse = ps2_key_data;
    end else if (run != 0) begin
      last_run = run;
      run = 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2d_drv = b;
    idle(HP);
    ps2c_drv = 1'b0;
    idle(HP);
    ps2c_drv = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) ps2_bit(bits[i]);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_good, input logic stop);
    logic par;
    par = par_good ? ~(^b) : (^b);
    send_bits({stop, par, b, 1'b0}, 11);
    ps2d_drv = 1'b1;
    idle(30);
  endtask

  task automatic expect_make(input string tag, input logic [7:0] b,
                             input logic [6:0] h1, input logic [6:0] h0);
    int p0;
    p0 = pulse_cnt;
    last_run = 0;
    send_frame(b, 1'b1, 1'b1);
    check_eq({tag, "_key_data"}, ps2_key_data, b);
    check_eq({tag, "_out"}, ps2_out, b);
    check_eq({tag, "_hex1"}, HEX1, h1);
    check_eq({tag, "_hex0"}, HEX0, h0);
    check_eq({tag, "_pulses"}, pulse_cnt - p0, 1);
    check_eq({tag, "_pulse_len"}, last_run, 1);
    check_eq({tag, "_data_at_pulse"}, data_at_pulse, b);
  endtask

  task automatic expect_quiet(input string tag, input logic [7:0] b, input logic par_good,
                              input logic stop, input logic [7:0] exp_data,
                              input logic [7:0] exp_out);
    int p0;
    p0 = pulse_cnt;
    send_frame(b, par_good, stop);
    check_eq({tag, "_key_data"}, ps2_key_data, exp_data);
    check_eq({tag, "_out"}, ps2_out, exp_out);
    check_eq({tag, "_pulses"}, pulse_cnt - p0, 0);
  endtask

  initial begin
    rst      = 1'b1;
    ps2c_drv = 1'b1;
    ps2d_drv = 1'b1;
    idle(5);
    check_eq("rst_key_data", ps2_key_data, 8'h00);
    check_eq("rst_out", ps2_out, 8'h00);
    check_eq("rst_hex0", HEX0, 7'h40);
    check_eq("rst_hex1", HEX1, 7'h40);
    check_eq("rst_pressed", ps2_key_pressed, 1'b0);
    check_eq("rst_clk1hz", clock_1hz, 1'b0);

    // divider: toggles after every 4th rising edge
    rst = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 3 || k == 4 || k == 7 || k == 8 || k == 13)
        check_eq($sformatf("div_k%0d", k), clock_1hz, (k / 4) % 2);
    end
    rst = 1'b1;
    @(negedge clk);
    check_eq("div_rst", clock_1hz, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k >= 3) check_eq($sformatf("div_restart_k%0d", k), clock_1hz, k / 4);
    end
    idle(20);

    // make codes
    expect_make("make_1c", 8'h1C, 7'h79, 7'h46);
    expect_make("make_29", 8'h29, 7'h24, 7'h10);

    // break sequence leaves ps2_out alone
    expect_quiet("brk_f0", 8'hF0, 1'b1, 1'b1, 8'hF0, 8'h29);
    expect_quiet("brk_1c", 8'h1C, 1'b1, 1'b1, 8'h1C, 8'h29);
    check_eq("brk_hex1", HEX1, 7'h24);
    check_eq("brk_hex0", HEX0, 7'h10);

    // corrupted frames are discarded
    expect_quiet("bad_parity", 8'h1C, 1'b0, 1'b1, 8'h1C, 8'h29);
    expect_quiet("bad_stop", 8'h1C, 1'b1, 1'b0, 8'h1C, 8'h29);
    expect_make("make_32", 8'h32, 7'h30, 7'h24);

    // extended make and extended break
    expect_quiet("ext_e0", 8'hE0, 1'b1, 1'b1, 8'hE0, 8'h32);
    expect_make("ext_make_75", 8'h75, 7'h78, 7'h12);
    expect_quiet("ext_brk_e0", 8'hE0, 1'b1, 1'b1, 8'hE0, 8'h75);
    expect_quiet("ext_brk_f0", 8'hF0, 1'b1, 1'b1, 8'hF0, 8'h75);
    expect_quiet("ext_brk_75", 8'h75, 1'b1, 1'b1, 8'h75, 8'h75);

    // partial frame then > TIMEOUT of silence
    send_bits({1'b1, 1'b1, 8'hFF, 1'b0}, 5);
    ps2d_drv = 1'b1;
    idle(420);
    expect_make("timeout_4b", 8'h4B, 7'h19, 7'h03);

    // 3-cycle low glitch on PS2_CLK with data low
    @(negedge clk);
    ps2d_drv = 1'b0;
    idle(5);
    ps2c_drv = 1'b0;
    idle(3);
    ps2c_drv = 1'b1;
    idle(5);
    ps2d_drv = 1'b1;
    idle(30);
    expect_make("glitch_a6", 8'hA6, 7'h08, 7'h02);

    // reset in the middle of a frame
    send_bits({1'b1, 1'b1, 8'h00, 1'b0}, 4);
    ps2d_drv = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    check_eq("midrst_key_data", ps2_key_data, 8'h00);
    check_eq("midrst_out", ps2_out, 8'h00);
    check_eq("midrst_hex0", HEX0, 7'h40);
    check_eq("midrst_hex1", HEX1, 7'h40);
    rst = 1'b0;
    idle(20);
    expect_make("midrst_5a", 8'h5A, 7'h12, 7'h08);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_display.md
PS2_KEYBOARD_DISPLAY -- requirements
Module: ps2_keyboard_display

Interface
- REQ-001 SHALL have one clock and an asynchronous, active-high reset, named as below.
- REQ-002 Parameter HALF_PERIOD, default 25_000_000: CLOCK_50 cycles per half period of clock_1hz.
- REQ-003 Parameter TIMEOUT, default 100_000: CLOCK_50 cycles (2 ms) without a PS2_CLK falling edge before a partial frame is abandoned.
- REQ-004 CLOCK_50  in  1  50 MHz system clock; all logic runs on its rising edge.
- REQ-005 reset  in  1  asynchronous, active-high reset.
- REQ-006 PS2_CLK  inout  1  keyboard clock; the block only receives and drives it high-Z.
- REQ-007 PS2_DAT  inout  1  keyboard data; the block only receives and drives it high-Z.
- REQ-008 ps2_key_data  out  8  last valid received byte, including F0/E0.
- REQ-009 ps2_key_pressed  out  1  one-cycle pulse when a make code is accepted.
- REQ-010 ps2_out  out  8  last accepted make code.
- REQ-011 HEX0  out  7  active-low segments {g,f,e,d,c,b,a} for ps2_out[3:0].
- REQ-012 HEX1  out  7  same encoding for ps2_out[7:4].
- REQ-013 clock_1hz  out  1  divided clock with 50% duty cycle.

Function
- REQ-014 PS2_CLK and PS2_DAT SHALL each pass through a 2-FF synchronizer.
- REQ-015 PS2_CLK SHALL also pass through an 8-sample glitch filter: the filtered level changes only after 8 identical consecutive samples.
- REQ-016 A falling edge of the filtered PS2_CLK SHALL sample PS2_DAT.
- REQ-017 Receiver states SHALL be IDLE, DATA, PARITY and STOP.
- REQ-018 IDLE SHALL leave to DATA only when a sampled start bit is 0.
- REQ-019 DATA SHALL shift in 8 bits LSB first.
- REQ-020 PARITY SHALL check for odd parity over data plus parity bit.
- REQ-021 STOP SHALL require the stop bit to be 1.
- REQ-022 A bad parity or stop bit SHALL silently discard the frame, return to IDLE and leave all outputs unchanged.
- REQ-023 If TIMEOUT cycles pass with no falling edge while not in IDLE, the receiver SHALL return to IDLE and discard the partial byte.
- REQ-024 On a valid frame, ps2_key_data SHALL update on the cycle after the stop-bit edge.
- REQ-025 Byte classification: E0 sets the extended flag only; F0 sets the break flag only.
- REQ-026 Any other byte with the break flag set SHALL clear both flags, with no pulse and no ps2_out change.
- REQ-027 Any other byte with the break flag clear is a make code: ps2_out <= byte, ps2_key_pressed = 1 for exactly one cycle (same cycle as the ps2_key_data update), and the extended flag clears.
- REQ-028 HEX0 and HEX1 SHALL be purely combinational from ps2_out, with zero latency.
- REQ-029 Seven-segment table (hex digit -> code): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- REQ-030 The divider counter SHALL count 0..HALF_PERIOD-1.
- REQ-031 On wrap the counter SHALL toggle clock_1hz, giving a period of exactly 2*HALF_PERIOD cycles.
- REQ-032 clock_1hz SHALL be a register output and SHALL NOT be used as a clock inside this block.

Reset
- REQ-033 reset SHALL force the receiver to IDLE and clear the shift register, bit count, timeout counter and both flags.
- REQ-034 reset SHALL set ps2_key_data=00, ps2_out=00 (HEX0=HEX1=40), ps2_key_pressed=0, divider count=0 and clock_1hz=0.
- REQ-035 Reset asserted mid-frame SHALL drop the frame; after release, the first falling edge SHALL be treated as a start bit.

Structure
- REQ-036 Package ps2_kbd_pkg SHALL hold: BREAK_CODE=F0, EXT_CODE=E0, the 16-entry segment table, the receiver state enum, and default HALF_PERIOD/TIMEOUT.
- REQ-037 One sub-module SHALL exist: ps2_rx (synchronizer, filter, frame FSM, timeout), outputting a byte plus a valid pulse.
- REQ-038 Make/break classification, seven-segment decode and the divider SHALL stay in the top module.

Verification
- REQ-039 Reset scenario: assert reset -> all outputs as in REQ-034; clock_1hz=0.
- REQ-040 Make code: frame 1C with good parity -> ps2_key_data=1C, one-cycle ps2_key_pressed, ps2_out=1C, HEX0=46, HEX1=79.
- REQ-041 Break: frames F0 then 1C after a 29 make -> no pulse, ps2_key_data=1C, ps2_out stays 29, HEX1=24, HEX0=10.
- REQ-042 Bad frame: frame 1C with even parity, then frame 1C with a 0 stop bit -> no output change and no pulse; a following valid 32 -> ps2_out=32.
- REQ-043 Timeout and glitch: 5 bits, then 2.1 ms idle, then valid 4B -> ps2_out=4B; a 3-cycle PS2_CLK glitch is ignored.
- REQ-044 Divider: HALF_PERIOD=4 -> clock_1hz toggles every 4 cycles; reset mid-count restarts the count at 0.
